id_ex_operand_stage: RTL and testbench
======================================

Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register directly upstream of the ALU.
- Latches decoded operands and control, and presents forwarded src1/src2 and ALUcontrol to the ALU.
- Resolves RAW hazards by forwarding from the EX/MEM and MEM/WB stages.
- Detects load-use hazards and inserts one bubble, stalling the decode stage.

Parameters:
- DATA_W, `INTERNAL_BITS (32), operand width.
- CTRL_W, `ALUCONTROL_BITS (4), ALU control width.
- REG_AW, 5, register address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous active-high.
- id_valid  in  1  decode stage presents a valid instruction.
- id_rs1_addr, id_rs2_addr  in  REG_AW  source register numbers.
- id_rd_addr  in  REG_AW  destination register.
- id_rs1_data, id_rs2_data  in  DATA_W  register-file read data.
- id_imm  in  DATA_W  sign-extended immediate.
- id_use_imm  in  1  src2 takes the immediate instead of rs2.
- id_alu_ctrl  in  CTRL_W  ALU operation code.
- id_reg_write, id_mem_read, id_mem_write  in  1  control bits.
- flush  in  1  kill the instruction being captured (branch taken).
- hold  in  1  downstream stall; freeze this stage.
- exmem_reg_write  in  1  EX/MEM stage writes a register.
- exmem_rd  in  REG_AW  EX/MEM destination.
- exmem_result  in  DATA_W  ALU Result[DATA_W-1:0] from EX/MEM. The overflow bit is not forwarded.
- memwb_reg_write  in  1  MEM/WB stage writes a register.
- memwb_rd  in  REG_AW  MEM/WB destination.
- memwb_data  in  DATA_W  MEM/WB writeback data.
- stall  out  1  load-use stall to the PC and IF/ID registers.
- ex_valid  out  1  registered valid of the EX instruction.
- src1, src2  out  DATA_W  forwarded ALU operands.
- ALUcontrol  out  CTRL_W  registered ALU op.
- ex_rd_addr  out  REG_AW  registered destination.
- ex_reg_write, ex_mem_read, ex_mem_write  out  1  registered control, gated by ex_valid.
- ex_store_data  out  DATA_W  forwarded rs2 value for stores.

Behaviour:
- Reset (async, immediate): all registered fields clear to 0.
  - ex_valid=0; ALUcontrol=4'b0000; ex_rd_addr=0; all control bits 0.
  - src1, src2 and ex_store_data read 0 while no forward matches.
- Latency: one cycle from ID inputs to registered EX fields. Forwarding muxes are combinational after the register.
- Load-use detection (combinational):
  - Condition: hazard = ex_valid & ex_mem_read & (ex_rd_addr!=0) & id_valid & (ex_rd_addr==id_rs1_addr | (ex_rd_addr==id_rs2_addr & (!id_use_imm | id_mem_write))).
  - stall = hazard & !hold.
- Capture per edge, in priority order:
  1. hold=1: every register holds; stall=0.
  2. flush=1: ex_valid<=0 and control bits <=0. Flush overrides stall.
  3. stall=1: bubble, i.e. ex_valid<=0 and control bits <=0. Upstream holds its inputs, so the instruction re-presents next cycle and the hazard has cleared.
  4. Otherwise: capture all id_* fields; ex_valid<=id_valid.
- src2 pre-mux: id_use_imm selects id_imm at capture. Store data is captured from rs2 separately.
- Forwarding, per operand (rs1 → src1; rs2 → store data, and src2 when not immediate):
  - EX/MEM wins: if exmem_reg_write & exmem_rd!=0 & exmem_rd==rs_q, the operand is exmem_result.
  - Else MEM/WB: if memwb_reg_write & memwb_rd!=0 & memwb_rd==rs_q, the operand is memwb_data.
  - Else the registered value.
  - Register 0 is never forwarded.
- The registered rs1/rs2 addresses and the use_imm flag are kept internally for forwarding.
- Simultaneous hold and flush: hold wins; the flush must be re-asserted.
- Reset mid-stall: stall drops immediately because ex_valid=0.
- No FSM beyond the ex_valid/ex_mem_read state. A bubble lasts exactly one cycle per load-use hazard.

Decomposition:
- def.v supplies `INTERNAL_BITS and `ALUCONTROL_BITS, and gains `REG_ADDR_BITS 5.
- ALU op codes (AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, MUL 1000, NOR 1100) move into def.v as shared constants.
- One sub-module, forward_mux: a 3:1 priority select with the rd!=0 check. It is instantiated three times: src1, src2, store data.

Test Plan:
- Reset: rst=1 mid-operation → ex_valid=0, ALUcontrol=0, src1=src2=0 without waiting for a clk edge.
- Plain capture: rs1_data=5, imm=7, use_imm=1, alu_ctrl=0010 → next cycle src1=5, src2=7, ALUcontrol=0010, ex_valid=1.
- Forward priority:
  - EX instr rs1=r3; exmem_rd=3 with exmem_result=0x10; memwb_rd=3 with memwb_data=0x20 → src1=0x10.
  - Drop exmem_reg_write → src1=0x20.
  - With exmem_rd=0 and memwb_rd=0 → register value.
- Load-use: lw r4 in EX, then an instruction using rs2=r4 with use_imm=0 → stall=1 for exactly one cycle and the bubble has ex_valid=0. The dependent instruction then enters with ex_valid=1.
- Flush and hold:
  - flush=1 during capture → ex_valid=0, ex_reg_write=0.
  - hold=1 together with flush=1 → all EX fields unchanged and stall=0.
- Store forwarding: sw with rs2=r6 and use_imm=1, memwb_rd=6 with memwb_data=0xAB → ex_store_data=0xAB, src2=imm.

Source files
------------

// File: rtl/id_ex_operand_stage_pkg.sv
// Shared widths, ALU op codes and the control bundle carried through the ID/EX register.
package id_ex_operand_stage_pkg;

    localparam int INTERNAL_BITS   = 32;
    localparam int ALUCONTROL_BITS = 4;
    localparam int REG_ADDR_BITS   = 5;

    typedef enum logic [ALUCONTROL_BITS-1:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_MUL = 4'b1000,
        ALU_NOR = 4'b1100
    } alu_op_e;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
    } ctrl_t;

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// Decode-side, bypass and EX-side signals of the ID/EX operand stage.
interface id_ex_operand_stage_if
    import id_ex_operand_stage_pkg::*;
#(
    parameter int DATA_W = INTERNAL_BITS,
    parameter int CTRL_W = ALUCONTROL_BITS,
    parameter int REG_AW = REG_ADDR_BITS
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1_addr;
    logic [REG_AW-1:0] id_rs2_addr;
    logic [REG_AW-1:0] id_rd_addr;
    logic [DATA_W-1:0] id_rs1_data;
    logic [DATA_W-1:0] id_rs2_data;
    logic [DATA_W-1:0] id_imm;
    logic              id_use_imm;
    logic [CTRL_W-1:0] id_alu_ctrl;
    logic              id_reg_write;
    logic              id_mem_read;
    logic              id_mem_write;
    logic              flush;
    logic              hold;
    logic              exmem_reg_write;
    logic [REG_AW-1:0] exmem_rd;
    logic [DATA_W-1:0] exmem_result;
    logic              memwb_reg_write;
    logic [REG_AW-1:0] memwb_rd;
    logic [DATA_W-1:0] memwb_data;

    logic              stall;
    logic              ex_valid;
    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
    logic [CTRL_W-1:0] ALUcontrol;
    logic [REG_AW-1:0] ex_rd_addr;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic              ex_mem_write;
    logic [DATA_W-1:0] ex_store_data;

    modport slave (
        input  id_valid, id_rs1_addr, id_rs2_addr, id_rd_addr, id_rs1_data, id_rs2_data,
               id_imm, id_use_imm, id_alu_ctrl, id_reg_write, id_mem_read, id_mem_write,
               flush, hold, exmem_reg_write, exmem_rd, exmem_result,
               memwb_reg_write, memwb_rd, memwb_data,
        output stall, ex_valid, src1, src2, ALUcontrol, ex_rd_addr,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_store_data
    );

    modport master (
        output id_valid, id_rs1_addr, id_rs2_addr, id_rd_addr, id_rs1_data, id_rs2_data,
               id_imm, id_use_imm, id_alu_ctrl, id_reg_write, id_mem_read, id_mem_write,
               flush, hold, exmem_reg_write, exmem_rd, exmem_result,
               memwb_reg_write, memwb_rd, memwb_data,
        input  stall, ex_valid, src1, src2, ALUcontrol, ex_rd_addr,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_store_data
    );

endinterface

// File: rtl/id_ex_operand_stage_forward_mux.sv
// 3:1 operand bypass: EX/MEM beats MEM/WB beats the latched value; r0 never bypasses.
// Purely combinational, no backpressure.
module id_ex_operand_stage_forward_mux
    import id_ex_operand_stage_pkg::*;
#(
    parameter int DATA_W = INTERNAL_BITS,
    parameter int REG_AW = REG_ADDR_BITS
) (
    input  logic              fwd_en_i,
    input  logic [REG_AW-1:0] rs_i,
    input  logic [DATA_W-1:0] reg_val_i,
    input  logic              exmem_we_i,
    input  logic [REG_AW-1:0] exmem_rd_i,
    input  logic [DATA_W-1:0] exmem_val_i,
    input  logic              memwb_we_i,
    input  logic [REG_AW-1:0] memwb_rd_i,
    input  logic [DATA_W-1:0] memwb_val_i,
    output logic [DATA_W-1:0] val_o
);

    logic exmem_hit;
    logic memwb_hit;

    always_comb begin
        exmem_hit = fwd_en_i && exmem_we_i && (exmem_rd_i != '0) && (exmem_rd_i == rs_i);
        memwb_hit = fwd_en_i && memwb_we_i && (memwb_rd_i != '0) && (memwb_rd_i == rs_i);
        val_o     = reg_val_i;
        if (exmem_hit) begin
            val_o = exmem_val_i;
        end else if (memwb_hit) begin
            val_o = memwb_val_i;
        end
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX register feeding the ALU: 1-cycle capture, combinational bypass after the register.
// hold freezes everything; a load-use hazard stalls decode and inserts a one-cycle bubble.
module id_ex_operand_stage
    import id_ex_operand_stage_pkg::*;
#(
    parameter int DATA_W = INTERNAL_BITS,
    parameter int CTRL_W = ALUCONTROL_BITS,
    parameter int REG_AW = REG_ADDR_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    id_ex_operand_stage_if.slave bus
);

    logic              valid_q,     valid_d;
    ctrl_t             ctrl_q,      ctrl_d;
    logic [CTRL_W-1:0] alu_q,       alu_d;
    logic [REG_AW-1:0] rd_q,        rd_d;
    logic [REG_AW-1:0] rs1_q,       rs1_d;
    logic [REG_AW-1:0] rs2_q,       rs2_d;
    logic              use_imm_q,   use_imm_d;
    logic [DATA_W-1:0] src1_q,      src1_d;
    logic [DATA_W-1:0] src2_q,      src2_d;
    logic [DATA_W-1:0] store_q,     store_d;

    logic hazard;
    logic stall_w;

    // A store still needs rs2 as data even when src2 takes the immediate.
    always_comb begin
        hazard = valid_q && ctrl_q.mem_read && (rd_q != '0) && bus.id_valid &&
                 ((rd_q == bus.id_rs1_addr) ||
                  ((rd_q == bus.id_rs2_addr) && (!bus.id_use_imm || bus.id_mem_write)));
        stall_w = hazard && !bus.hold;
    end

    always_comb begin
        valid_d   = valid_q;
        ctrl_d    = ctrl_q;
        alu_d     = alu_q;
        rd_d      = rd_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        use_imm_d = use_imm_q;
        src1_d    = src1_q;
        src2_d    = src2_q;
        store_d   = store_q;
        if (bus.hold) begin
            valid_d = valid_q;
        end else if (bus.flush || stall_w) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else begin
            valid_d          = bus.id_valid;
            ctrl_d.reg_write = bus.id_reg_write;
            ctrl_d.mem_read  = bus.id_mem_read;
            ctrl_d.mem_write = bus.id_mem_write;
            alu_d            = bus.id_alu_ctrl;
            rd_d             = bus.id_rd_addr;
            rs1_d            = bus.id_rs1_addr;
            rs2_d            = bus.id_rs2_addr;
            use_imm_d        = bus.id_use_imm;
            src1_d           = bus.id_rs1_data;
            src2_d           = bus.id_use_imm ? bus.id_imm : bus.id_rs2_data;
            store_d          = bus.id_rs2_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= 1'b0;
            ctrl_q    <= '0;
            alu_q     <= '0;
            rd_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            use_imm_q <= 1'b0;
            src1_q    <= '0;
            src2_q    <= '0;
            store_q   <= '0;
        end else begin
            valid_q   <= valid_d;
            ctrl_q    <= ctrl_d;
            alu_q     <= alu_d;
            rd_q      <= rd_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            use_imm_q <= use_imm_d;
            src1_q    <= src1_d;
            src2_q    <= src2_d;
            store_q   <= store_d;
        end
    end

    id_ex_operand_stage_forward_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_src1 (
        .fwd_en_i    (1'b1),
        .rs_i        (rs1_q),
        .reg_val_i   (src1_q),
        .exmem_we_i  (bus.exmem_reg_write),
        .exmem_rd_i  (bus.exmem_rd),
        .exmem_val_i (bus.exmem_result),
        .memwb_we_i  (bus.memwb_reg_write),
        .memwb_rd_i  (bus.memwb_rd),
        .memwb_val_i (bus.memwb_data),
        .val_o       (bus.src1)
    );

    // An immediate operand must never be replaced by a bypassed rs2 value.
    id_ex_operand_stage_forward_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_src2 (
        .fwd_en_i    (!use_imm_q),
        .rs_i        (rs2_q),
        .reg_val_i   (src2_q),
        .exmem_we_i  (bus.exmem_reg_write),
        .exmem_rd_i  (bus.exmem_rd),
        .exmem_val_i (bus.exmem_result),
        .memwb_we_i  (bus.memwb_reg_write),
        .memwb_rd_i  (bus.memwb_rd),
        .memwb_val_i (bus.memwb_data),
        .val_o       (bus.src2)
    );

    id_ex_operand_stage_forward_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_store (
        .fwd_en_i    (1'b1),
        .rs_i        (rs2_q),
        .reg_val_i   (store_q),
        .exmem_we_i  (bus.exmem_reg_write),
        .exmem_rd_i  (bus.exmem_rd),
        .exmem_val_i (bus.exmem_result),
        .memwb_we_i  (bus.memwb_reg_write),
        .memwb_rd_i  (bus.memwb_rd),
        .memwb_val_i (bus.memwb_data),
        .val_o       (bus.ex_store_data)
    );

    assign bus.stall        = stall_w;
    assign bus.ex_valid     = valid_q;
    assign bus.ALUcontrol   = alu_q;
    assign bus.ex_rd_addr   = rd_q;
    assign bus.ex_reg_write = ctrl_q.reg_write & valid_q;
    assign bus.ex_mem_read  = ctrl_q.mem_read  & valid_q;
    assign bus.ex_mem_write = ctrl_q.mem_write & valid_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: capture, bypass priority, load-use bubble, flush/hold, store bypass.
module tb_id_ex_operand_stage;
    import id_ex_operand_stage_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    id_ex_operand_stage_if bus ();

    id_ex_operand_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.id_valid        = 1'b0;
        bus.id_rs1_addr     = '0;
        bus.id_rs2_addr     = '0;
        bus.id_rd_addr      = '0;
        bus.id_rs1_data     = '0;
        bus.id_rs2_data     = '0;
        bus.id_imm          = '0;
        bus.id_use_imm      = 1'b0;
        bus.id_alu_ctrl     = '0;
        bus.id_reg_write    = 1'b0;
        bus.id_mem_read     = 1'b0;
        bus.id_mem_write    = 1'b0;
        bus.flush           = 1'b0;
        bus.hold            = 1'b0;
        bus.exmem_reg_write = 1'b0;
        bus.exmem_rd        = '0;
        bus.exmem_result    = '0;
        bus.memwb_reg_write = 1'b0;
        bus.memwb_rd        = '0;
        bus.memwb_data      = '0;
    endtask

    // Present one decoded instruction on the ID side.
    task automatic present(input logic [4:0] rs1, input logic [31:0] d1,
                           input logic [4:0] rs2, input logic [31:0] d2,
                           input logic [31:0] imm, input logic use_imm,
                           input logic [4:0] rd, input logic [3:0] op,
                           input logic rw, input logic mr, input logic mw);
        bus.id_valid     = 1'b1;
        bus.id_rs1_addr  = rs1;
        bus.id_rs1_data  = d1;
        bus.id_rs2_addr  = rs2;
        bus.id_rs2_data  = d2;
        bus.id_imm       = imm;
        bus.id_use_imm   = use_imm;
        bus.id_rd_addr   = rd;
        bus.id_alu_ctrl  = op;
        bus.id_reg_write = rw;
        bus.id_mem_read  = mr;
        bus.id_mem_write = mw;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        clear_inputs();
        #2;
        chk("reset_ex_valid",  bus.ex_valid,     0);
        chk("reset_aluctrl",   bus.ALUcontrol,   0);
        chk("reset_src1",      bus.src1,         0);
        chk("reset_src2",      bus.src2,         0);
        chk("reset_store",     bus.ex_store_data, 0);
        chk("reset_stall",     bus.stall,        0);
        #1;
        rst = 1'b0;
        tick();

        // Plain capture: rs1=5, imm=7 into src2, ADD.
        present(5'd1, 32'd5, 5'd2, 32'd99, 32'd7, 1'b1, 5'd8, ALU_ADD, 1'b1, 1'b0, 1'b0);
        tick();
        chk("cap_src1",     bus.src1,         32'd5);
        chk("cap_src2",     bus.src2,         32'd7);
        chk("cap_aluctrl",  bus.ALUcontrol,   ALU_ADD);
        chk("cap_ex_valid", bus.ex_valid,     1);
        chk("cap_rd",       bus.ex_rd_addr,   8);
        chk("cap_reg_write", bus.ex_reg_write, 1);

        // Bypass priority on src1 = r3, src2 = r5 register operand.
        present(5'd3, 32'h99, 5'd5, 32'h55, 32'h0, 1'b0, 5'd10, ALU_SUB, 1'b1, 1'b0, 1'b0);
        tick();
        bus.id_valid        = 1'b0;
        bus.exmem_reg_write = 1'b1;
        bus.exmem_rd        = 5'd3;
        bus.exmem_result    = 32'h10;
        bus.memwb_reg_write = 1'b1;
        bus.memwb_rd        = 5'd3;
        bus.memwb_data      = 32'h20;
        #1;
        chk("fwd_exmem_wins", bus.src1, 32'h10);
        chk("fwd_src2_nomatch", bus.src2, 32'h55);
        bus.exmem_reg_write = 1'b0;
        #1;
        chk("fwd_memwb", bus.src1, 32'h20);
        bus.exmem_reg_write = 1'b1;
        bus.exmem_rd        = 5'd0;
        bus.memwb_rd        = 5'd0;
        #1;
        chk("fwd_r0_never", bus.src1, 32'h99);
        bus.memwb_rd = 5'd5;
        #1;
        chk("fwd_src2_memwb", bus.src2, 32'h20);

        // Asynchronous reset mid-operation, with a live EX/MEM match on r3.
        bus.exmem_rd = 5'd3;
        rst          = 1'b1;
        #1;
        chk("areset_ex_valid", bus.ex_valid,   0);
        chk("areset_aluctrl",  bus.ALUcontrol, 0);
        chk("areset_src1",     bus.src1,       0);
        chk("areset_src2",     bus.src2,       0);
        rst = 1'b0;
        clear_inputs();
        tick();

        // Load-use: lw r4, then a consumer reading r4 through rs2.
        present(5'd1, 32'h0, 5'd0, 32'h0, 32'h4, 1'b1, 5'd4, ALU_ADD, 1'b1, 1'b1, 1'b0);
        tick();
        chk("lw_mem_read", bus.ex_mem_read, 1);
        present(5'd7, 32'h70, 5'd4, 32'h0, 32'h0, 1'b0, 5'd9, ALU_OR, 1'b1, 1'b0, 1'b0);
        #1;
        chk("lu_stall_on", bus.stall, 1);
        tick();
        chk("lu_bubble_valid", bus.ex_valid,     0);
        chk("lu_bubble_rw",    bus.ex_reg_write, 0);
        chk("lu_stall_off",    bus.stall,        0);
        tick();
        chk("lu_dep_valid", bus.ex_valid,   1);
        chk("lu_dep_op",    bus.ALUcontrol, ALU_OR);
        chk("lu_dep_rd",    bus.ex_rd_addr, 9);

        // Immediate consumer of a load that only matches rs2 does not stall.
        present(5'd1, 32'h0, 5'd0, 32'h0, 32'h4, 1'b1, 5'd4, ALU_ADD, 1'b1, 1'b1, 1'b0);
        tick();
        present(5'd7, 32'h70, 5'd4, 32'h0, 32'h3, 1'b1, 5'd9, ALU_OR, 1'b1, 1'b0, 1'b0);
        #1;
        chk("lu_imm_nostall", bus.stall, 0);

        // Flush during capture.
        bus.flush = 1'b1;
        tick();
        chk("flush_valid", bus.ex_valid,     0);
        chk("flush_rw",    bus.ex_reg_write, 0);
        bus.flush = 1'b0;

        // Hold together with flush freezes a load in EX and masks its hazard.
        present(5'd1, 32'h0, 5'd0, 32'h0, 32'h8, 1'b1, 5'd12, ALU_ADD, 1'b1, 1'b1, 1'b0);
        tick();
        present(5'd12, 32'h0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd13, ALU_SUB, 1'b1, 1'b0, 1'b0);
        bus.hold  = 1'b1;
        bus.flush = 1'b1;
        #1;
        chk("hold_stall_masked", bus.stall, 0);
        tick();
        chk("hold_valid",   bus.ex_valid,    1);
        chk("hold_op",      bus.ALUcontrol,  ALU_ADD);
        chk("hold_rd",      bus.ex_rd_addr,  12);
        chk("hold_memread", bus.ex_mem_read, 1);
        bus.hold  = 1'b0;
        bus.flush = 1'b0;
        #1;
        chk("unhold_stall", bus.stall, 1);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;

        // Store: sw rs2=r6 with immediate offset.
        present(5'd2, 32'h100, 5'd6, 32'h66, 32'h8, 1'b1, 5'd0, ALU_ADD, 1'b0, 1'b0, 1'b1);
        tick();
        bus.id_valid = 1'b0;
        chk("st_store_reg", bus.ex_store_data, 32'h66);
        chk("st_mem_write", bus.ex_mem_write,  1);
        bus.memwb_reg_write = 1'b1;
        bus.memwb_rd        = 5'd6;
        bus.memwb_data      = 32'hAB;
        #1;
        chk("st_store_memwb", bus.ex_store_data, 32'hAB);
        chk("st_src2_imm",    bus.src2,          32'h8);
        bus.exmem_reg_write = 1'b1;
        bus.exmem_rd        = 5'd6;
        bus.exmem_result    = 32'hCD;
        #1;
        chk("st_store_exmem", bus.ex_store_data, 32'hCD);
        chk("st_src2_imm2",   bus.src2,          32'h8);
        chk("st_src1",        bus.src1,          32'h100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
